// File: rtl/dmem_bus_pkg.sv
// Shared definitions for the data-side bus interface: access size codes,
// controller states and the request legality check.
package dmem_bus_pkg;

    // Access size codes, shared by req_size and the SIZE bus output
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    // True when a request must be refused without a bus cycle: illegal size
    // code, or an access not aligned to its own size.
    function automatic logic req_illegal(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data extraction: picks the right-justified halfword/byte from the bus
// word and sign- or zero-extends it. Purely combinational so the fetch side
// can reuse it.
module dmem_load_align
    import dmem_bus_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_data,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    output logic [DW-1:0] o_data
);

    // Size-dependent extension of the returned bus data
    always_comb begin
        // NOTE: default assignment first so every path drives o_data (no latch).
        o_data = i_data;
        case (i_size)
            SZ_HALF: o_data = {{(DW-16){i_signed & i_data[15]}}, i_data[15:0]};
            SZ_BYTE: o_data = {{(DW-8){i_signed & i_data[7]}}, i_data[7:0]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Data-side bus interface unit. Accepts one load/store at a time, runs a
// single bus transaction (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n), and returns a
// one-cycle response pulse. Misaligned or illegal-size requests are answered
// with resp_err without touching the bus.
// Optional build macro DMEM_BUS_TIMEOUT_EN adds a BUSY watchdog of
// TIMEOUT_CYC cycles that ends a stuck transaction with resp_err.
module dmem_bus_if
    import dmem_bus_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] DAD,
    output logic          MREQ,
    output logic          WRITE,
    output logic [1:0]    SIZE,
    inout  wire  [DW-1:0] DDT,
    input  logic          ACKD_n
);

    state_t        r_state;
    logic [AW-1:0] r_dad;
    logic          r_mreq;
    logic          r_write;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [DW-1:0] r_wdata;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [DW-1:0] r_resp_rdata;

    logic          w_illegal;
    logic          w_start;
    logic          w_timeout;
    logic [DW-1:0] w_store_lane;
    logic [DW-1:0] w_load_data;

    assign w_illegal = req_illegal(req_size, req_addr[1:0]);
    // A legal request accepted this edge opens a bus cycle
    assign w_start   = req_valid && (r_state != BUSY) && !w_illegal;

    // Right-justified store data placed on its bus lanes, upper lanes zero
    always_comb begin
        w_store_lane = req_wdata;
        case (req_size)
            SZ_HALF: w_store_lane = {{(DW-16){1'b0}}, req_wdata[15:0]};
            SZ_BYTE: w_store_lane = {{(DW-8){1'b0}}, req_wdata[7:0]};
            default: w_store_lane = req_wdata;
        endcase
    end

    dmem_load_align #(
        .DW(DW)
    ) u_load_align (
        .i_data  (DDT),
        .i_size  (r_size),
        .i_signed(r_signed),
        .o_data  (w_load_data)
    );

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Last BUSY cycle before the watchdog gives up
    assign w_timeout = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // BUSY cycle counter, cleared whenever a bus cycle opens
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Transaction controller: state plus all registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: reset is asynchronous and clears every output register, so a
        // transaction in flight is dropped with no response.
        if (rst) begin
            r_state      <= IDLE;
            r_dad        <= '0;
            r_mreq       <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= SZ_WORD;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            // NOTE: non-blocking assignments only; the response defaults below
            // make resp_valid a single-cycle pulse unless overridden.
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                IDLE, RESP: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state  <= BUSY;
                            r_dad    <= req_addr;
                            r_write  <= req_write;
                            r_size   <= req_size;
                            r_signed <= req_signed;
                            r_wdata  <= w_store_lane;
                            r_mreq   <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                BUSY: begin
                    if (!ACKD_n) begin
                        r_state      <= RESP;
                        r_mreq       <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= r_write ? '0 : w_load_data;
                    end else if (w_timeout) begin
                        r_state      <= RESP;
                        r_mreq       <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store data is driven only while a write bus cycle is open
    assign DDT        = (r_mreq && r_write) ? r_wdata : {DW{1'bz}};

    assign req_ready  = (r_state != BUSY);
    assign DAD        = r_dad;
    assign MREQ       = r_mreq;
    assign WRITE      = r_write;
    assign SIZE       = r_size;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed vector table, back-to-back,
// randomized traffic against a byte-array memory model, watchdog behaviour
// (DMEM_BUS_TIMEOUT_EN on or off), and reset in the middle of a bus cycle.
module tb_dmem_bus_if;

    localparam int          TO    = 8;
    localparam logic [31:0] PROBE = 32'h5AA5_C33C;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] DAD;
    logic        MREQ, WRITE;
    logic [1:0]  SIZE;
    logic        ACKD_n;
    wire  [31:0] ddt;

    // Bench side of the bus: memory data for loads, a probe pattern otherwise
    logic        tb_drv;
    logic [31:0] tb_val;
    assign ddt = tb_drv ? tb_val : 'z;

    always #5 clk = ~clk;

    dmem_bus_if #(
        .AW(32), .DW(32), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
        .DDT(ddt), .ACKD_n(ACKD_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [logic [31:0]];

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wd;
        int          k;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] ddt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    function automatic logic illegal_ref(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd0) return (a % 4) != 0;
        if (sz == 2'd1) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] load_ref(input logic [1:0] sz, input logic sgn, input logic [31:0] a);
        int v;
        if (sz == 2'd0) return {rd(a), rd(a + 1), rd(a + 2), rd(a + 3)};
        if (sz == 2'd1) begin
            v = rd(a) * 256 + rd(a + 1);
            if (sgn && v >= 32768) v = v - 65536;
        end else begin
            v = rd(a);
            if (sgn && v >= 128) v = v - 256;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] store_bus_ref(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd1) return wd % 32'h1_0000;
        if (sz == 2'd2) return wd % 32'h100;
        return wd;
    endfunction

    task automatic mem_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        if (sz == 2'd0) begin
            mem[a] = wd[31:24]; mem[a + 1] = wd[23:16]; mem[a + 2] = wd[15:8]; mem[a + 3] = wd[7:0];
        end else if (sz == 2'd1) begin
            mem[a] = wd[15:8]; mem[a + 1] = wd[7:0];
        end else begin
            mem[a] = wd[7:0];
        end
    endtask

    // Data the memory returns for a load: right-justified, noise above it
    function automatic logic [31:0] bus_load(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] noise;
        noise = $urandom;
        if (sz == 2'd0) return {rd(a), rd(a + 1), rd(a + 2), rd(a + 3)};
        if (sz == 2'd1) return {noise[31:16], rd(a), rd(a + 1)};
        return {noise[31:8], rd(a)};
    endfunction

    // One request from a negedge; returns at negedge+1 of its response cycle
    task automatic do_txn(input string name, input logic wr, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input int k, input logic exp_err, input logic [31:0] exp_rdata,
                          input logic [31:0] exp_ddt);
        logic [31:0] bus_rd;
        bus_rd     = bus_load(sz, addr);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        tb_drv     = !(wr && !exp_err);
        tb_val     = PROBE;
        #1;
        check({name, " ready_at_accept"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        if (exp_err) begin
            #1;
            check({name, " err_valid"}, resp_valid, 1);
            check({name, " err_flag"}, resp_err, 1);
            check({name, " err_rdata"}, resp_rdata, 0);
            check({name, " err_no_mreq"}, MREQ, 0);
            check({name, " err_ddt_z"}, ddt, PROBE);
        end else begin
            for (int j = 1; j <= k; j++) begin
                if (!wr) begin
                    tb_drv = 1'b1;
                    tb_val = bus_rd;
                end
                ACKD_n = (j == k) ? 1'b0 : 1'b1;
                #1;
                check({name, " busy_mreq"}, MREQ, 1);
                check({name, " busy_ready"}, req_ready, 0);
                check({name, " busy_no_resp"}, resp_valid, 0);
                check({name, " DAD"}, DAD, addr);
                check({name, " WRITE"}, WRITE, wr);
                check({name, " SIZE"}, SIZE, sz);
                if (wr) check({name, " store_ddt"}, ddt, exp_ddt);
                @(negedge clk);
            end
            ACKD_n = 1'b1;
            tb_drv = 1'b1;
            tb_val = PROBE;
            #1;
            check({name, " resp_valid"}, resp_valid, 1);
            check({name, " resp_err"}, resp_err, 0);
            check({name, " resp_rdata"}, resp_rdata, exp_rdata);
            check({name, " resp_mreq_low"}, MREQ, 0);
            check({name, " resp_ddt_z"}, ddt, PROBE);
            check({name, " resp_ready"}, req_ready, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; ACKD_n = 1'b1; tb_drv = 1'b1; tb_val = PROBE;

        mem[BASE + 32'h10] = 8'h12; mem[BASE + 32'h11] = 8'h34;
        mem[BASE + 32'h12] = 8'h56; mem[BASE + 32'h13] = 8'h78;
        mem[BASE + 32'h03] = 8'hF0;
        mem[BASE + 32'h04] = 8'h80; mem[BASE + 32'h05] = 8'h01;

        //          wr    sz     sgn   addr                wdata          k  err   rdata          ddt
        vecs[0]  = '{1'b0, 2'b00, 1'b0, BASE + 32'h10, 32'h0,          1, 1'b0, 32'h1234_5678, 32'h0};
        vecs[1]  = '{1'b0, 2'b10, 1'b1, BASE + 32'h03, 32'h0,          1, 1'b0, 32'hFFFF_FFF0, 32'h0};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, BASE + 32'h03, 32'h0,          2, 1'b0, 32'h0000_00F0, 32'h0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, BASE + 32'h04, 32'h0,          1, 1'b0, 32'hFFFF_8001, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, BASE + 32'h04, 32'h0,          3, 1'b0, 32'h0000_8001, 32'h0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, BASE + 32'h02, 32'hDEAD_BEEF,  1, 1'b0, 32'h0,         32'h0000_BEEF};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, BASE + 32'h01, 32'h0,          1, 1'b1, 32'h0,         32'h0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, BASE + 32'h00, 32'h0,          1, 1'b1, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, BASE + 32'h05, 32'h1234_5678,  1, 1'b1, 32'h0,         32'h0};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h07, 32'h1234_5678,  3, 1'b0, 32'h0,         32'h0000_0078};
        vecs[10] = '{1'b1, 2'b00, 1'b0, BASE + 32'h20, 32'hCAFE_F00D,  2, 1'b0, 32'h0,         32'hCAFE_F00D};
        vecs[11] = '{1'b0, 2'b00, 1'b0, BASE + 32'h10, 32'h0,          4, 1'b0, 32'h1234_5678, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst MREQ", MREQ, 0);
        check("rst WRITE", WRITE, 0);
        check("rst SIZE", SIZE, 0);
        check("rst DAD", DAD, 0);
        check("rst DDT_z", ddt, PROBE);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_err", resp_err, 0);
        check("rst resp_rdata", resp_rdata, 0);
        check("rst req_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sgn, vecs[i].addr,
                   vecs[i].wd, vecs[i].k, vecs[i].err, vecs[i].rdata, vecs[i].ddt);
            if (vecs[i].wr && !vecs[i].err) mem_store(vecs[i].sz, vecs[i].addr, vecs[i].wd);
            @(negedge clk);
        end

        // Back-to-back: ack held high 5 cycles, second request during RESP
        do_txn("b2b_first", 1'b0, 2'b00, 1'b0, BASE + 32'h10, 32'h0, 6, 1'b0, 32'h1234_5678, 32'h0);
        do_txn("b2b_second", 1'b1, 2'b10, 1'b0, BASE + 32'h30, 32'h0000_00A5, 1, 1'b0, 32'h0, 32'h0000_00A5);
        mem_store(2'b10, BASE + 32'h30, 32'h0000_00A5);
        @(negedge clk);

        // Randomized traffic against the memory model
        for (int i = 0; i < 200; i++) begin
            logic        wr, sgn, err;
            logic [1:0]  sz;
            logic [31:0] addr, wd, exp_rd;
            int          k;
            wr   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sgn  = 1'($urandom_range(0, 1));
            addr = BASE + $urandom_range(0, 63);
            wd   = $urandom;
            k    = $urandom_range(1, 4);
            err  = illegal_ref(sz, addr);
            exp_rd = (err || wr) ? 32'h0 : load_ref(sz, sgn, addr);
            do_txn($sformatf("rnd%0d", i), wr, sz, sgn, addr, wd, k, err, exp_rd, store_bus_ref(sz, wd));
            if (wr && !err) mem_store(sz, addr, wd);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        // Watchdog: ack never given
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = BASE + 32'h40;
        @(negedge clk);
        req_valid = 1'b0;
`ifdef DMEM_BUS_TIMEOUT_EN
        for (int j = 0; j < TO; j++) begin
            #1;
            check("to busy_mreq", MREQ, 1);
            check("to busy_no_resp", resp_valid, 0);
            @(negedge clk);
        end
        #1;
        check("to mreq_dropped", MREQ, 0);
        check("to resp_valid", resp_valid, 1);
        check("to resp_err", resp_err, 1);
        check("to resp_rdata", resp_rdata, 0);
        @(negedge clk);
`else
        repeat (40) @(negedge clk);
        #1;
        check("nowd mreq_held", MREQ, 1);
        check("nowd no_resp", resp_valid, 0);
        check("nowd ready_low", req_ready, 0);
        ACKD_n = 1'b0;
        @(negedge clk);
        ACKD_n = 1'b1;
        #1;
        check("nowd resp_valid", resp_valid, 1);
        check("nowd mreq_low", MREQ, 0);
        @(negedge clk);
`endif

        // Reset in the middle of a store bus cycle
        tb_drv = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = BASE + 32'h44;
        req_wdata = 32'h1122_3344;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("mid mreq_before", MREQ, 1);
        check("mid ddt_before", ddt, 32'h1122_3344);
        #1 rst = 1'b1;
        #1;
        check("mid mreq_cleared", MREQ, 0);
        check("mid ready", req_ready, 1);
        check("mid DAD", DAD, 0);
        tb_drv = 1'b1; tb_val = PROBE;
        #1;
        check("mid ddt_z", ddt, PROBE);
        @(negedge clk);
        rst = 1'b0;
        ACKD_n = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            check("mid no_resp", resp_valid, 0);
            check("mid idle_ack_ignored", MREQ, 0);
        end
        ACKD_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_if.md
Name: dmem_bus_if

Overview:
- Data-side bus interface unit inside `top`, between the pipeline's memory stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one load/store request at a time and drives a single bus transaction.
- Waits for ACKD_n; for loads, aligns and extends the returned data; for stores, lane-places the write data.
- Backpressures the pipeline via req_ready while a transaction is outstanding.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte lanes big-endian: DDT[31:24] is the byte at address+0).
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  memory-stage request present.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 halfword, 10 byte, 11 illegal.
- req_signed  in  1  loads only: sign-extend (1) or zero-extend (0).
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-justified.
- req_ready  out  1  request accepted at an edge when req_valid && req_ready.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size, or timeout.
- DAD  out  AW  bus address.
- MREQ  out  1  bus request.
- WRITE  out  1  bus direction.
- SIZE  out  2  bus access size, same encoding as req_size.
- DDT  inout  DW  bus data.
- ACKD_n  in  1  active-low acknowledge, sampled on rising edge.

Behaviour:
- Reset (async, immediate), all outputs:
  - MREQ=0, WRITE=0, SIZE=00, DAD=0.
  - DDT high-Z.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - req_ready=1.
  - State IDLE.
  - Reset mid-transaction abandons the transaction with no response.
- States: IDLE, BUSY, RESP.
  - req_ready = (state != BUSY).
- IDLE/RESP, request accepted at edge N:
  - If the request is legal: go to BUSY. DAD/WRITE/SIZE/MREQ registered from the request (MREQ=1 from edge N). Write lane data registered too.
  - If the request is illegal: no bus cycle. Go to RESP; resp_valid=1, resp_err=1 in cycle N+1.
  - Illegal means: size 11; halfword with addr[0]=1; word with addr[1:0]!=0.
- RESP with no new request: return to IDLE.
- Back-to-back: a request accepted in the RESP cycle starts its bus cycle at the next edge (no idle bubble).
- BUSY: hold DAD/WRITE/SIZE/MREQ stable.
  - At the first edge with ACKD_n=0: MREQ=0, go to RESP, resp_valid=1 in the following cycle.
  - ACKD_n=0 while not BUSY is ignored.
- Latency: memory ack latency k yields resp_valid in cycle N+k+1 relative to acceptance edge N. With k=1, resp_valid arrives 2 cycles after acceptance.
- Store lane placement on DDT (driven only while MREQ && WRITE, else high-Z):
  - Word: wdata[31:0].
  - Half: {16'h0, wdata[15:0]}.
  - Byte: {24'h0, wdata[7:0]}.
- Load capture at the ack edge, from DDT:
  - Word: DDT.
  - Half: DDT[15:0], extended per req_signed.
  - Byte: DDT[7:0], extended per req_signed.
  - The signed flag is latched at acceptance.
- Stores complete with resp_rdata=0. No special treatment of any address; STDOUT/EXIT-mapped addresses are ordinary stores.

Optional Feature:
- Macro: DMEM_BUS_TIMEOUT_EN.
- With the macro defined: a cycle counter clears on entering BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYC without an ack:
  - drop MREQ;
  - go to RESP;
  - resp_valid=1, resp_err=1, resp_rdata=0.
- Without the macro: no counter is present; BUSY waits indefinitely.

Decomposition:
- Package/header dmem_bus_pkg holds:
  - SIZE encodings: SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - State encodings: IDLE/BUSY/RESP.
  - Misalignment check function.
- One sub-module: dmem_load_align. Combinational size/sign extension of DDT into resp_rdata, reused by the fetch side later.

Test Plan:
- Word load, addr 0x80000010, memory bytes 12 34 56 78, ack latency 1 -> MREQ=1, WRITE=0, SIZE=00 one cycle; resp_valid 2 cycles after acceptance; resp_rdata=0x12345678; resp_err=0.
- Byte load, addr 0x80000003, byte 0xF0 -> signed gives 0xFFFFFFF0; unsigned gives 0x000000F0. Halfword 0x8001 signed -> 0xFFFF8001.
- Halfword store, wdata 0xDEADBEEF, addr 0x80000002 -> DDT=0x0000BEEF while MREQ && WRITE; DDT high-Z otherwise; resp_rdata=0.
- Misaligned word load at 0x80000001, and size 11 -> MREQ never asserts; resp_valid && resp_err one cycle after acceptance.
- Ack held high 5 cycles, then low; second request presented during RESP -> req_ready=0 throughout BUSY; second bus cycle begins the edge after RESP. Separately, assert rst mid-BUSY -> MREQ=0 and DDT=Z immediately, with no resp_valid.
- With DMEM_BUS_TIMEOUT_EN and TIMEOUT_CYC=8, ack never given -> MREQ drops after 8 BUSY cycles; resp_err=1. Without the macro, MREQ stays high indefinitely.
